// File: rtl/fc_weight_scheduler.sv
// fc_weight_scheduler
// Steps a MAC through NUM_WEIGHTS weight sets of FEAT_LEN pooled-feature beats.
// Each set ends with a one-cycle FLUSH in which acc_in holds the final sum.
// Optional feature macro: FC_ARGMAX_EN builds the argmax tracker that reports
// the index of the set with the largest signed sum.
module fc_weight_scheduler #(
    parameter int unsigned FEAT_LEN    = 28,
    parameter int unsigned NUM_WEIGHTS = 10,
    parameter int unsigned ACC_W       = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             pool_valid,
    input  logic             mac_ready,
    input  logic [ACC_W-1:0] acc_in,
    output logic             pool_read_en,
    output logic [3:0]       weight_num,
    output logic [4:0]       feat_idx,
    output logic             acc_clear,
    output logic             result_valid,
    output logic             busy,
    output logic             done,
    output logic [3:0]       class_id,
    output logic             class_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [4:0] FEAT_LAST   = 5'(FEAT_LEN - 1);
    localparam logic [3:0] WEIGHT_LAST = 4'(NUM_WEIGHTS - 1);

    state_t     state_q;
    logic [3:0] weight_q;
    logic [4:0] feat_q;
    logic       acc_clear_q;
    logic       result_valid_q;
    logic       done_q;
    logic       beat;

    // A beat is consumed only while running and both sides are ready.
    assign beat = (state_q == S_RUN) && pool_valid && mac_ready && !abort;

    // Pass sequencer: counters, state and the registered strobes.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            state_q        <= S_IDLE;
            weight_q       <= '0;
            feat_q         <= '0;
            acc_clear_q    <= 1'b0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            acc_clear_q    <= 1'b0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_RUN;
                        weight_q    <= '0;
                        feat_q      <= '0;
                        acc_clear_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (beat) begin
                        if (feat_q == FEAT_LAST) begin
                            state_q        <= S_FLUSH;
                            result_valid_q <= 1'b1;
                        end else begin
                            feat_q <= feat_q + 5'd1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (weight_q == WEIGHT_LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q     <= S_RUN;
                        weight_q    <= weight_q + 4'd1;
                        feat_q      <= '0;
                        acc_clear_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q  <= S_IDLE;
                    weight_q <= '0;
                    feat_q   <= '0;
                end
                default: begin
                    state_q  <= S_IDLE;
                    weight_q <= '0;
                    feat_q   <= '0;
                end
            endcase
        end
    end

    assign pool_read_en = beat;
    assign weight_num   = weight_q;
    assign feat_idx     = feat_q;
    assign acc_clear    = acc_clear_q;
    // abort cancels the pass in the same cycle, so it also masks the strobes
    assign result_valid = result_valid_q && !abort;
    assign done         = done_q && !abort;
    assign busy         = (state_q != S_IDLE);

`ifdef FC_ARGMAX_EN
    logic signed [ACC_W-1:0] max_q;
    logic [3:0]              class_q;
    logic                    class_valid_q;
    logic                    take_d;

    // The first set always loads; later sets replace only on a strictly larger sum.
    always_comb begin
        take_d = (state_q == S_FLUSH) &&
                 ((weight_q == '0) || ($signed(acc_in) > max_q));
    end

    // Argmax tracker and result-valid flag.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            max_q         <= '0;
            class_q       <= '0;
            class_valid_q <= 1'b0;
        end else begin
            if (take_d) begin
                max_q   <= $signed(acc_in);
                class_q <= weight_q;
            end
            if ((state_q == S_IDLE) && start) begin
                class_valid_q <= 1'b0;
            end else if ((state_q == S_FLUSH) && (weight_q == WEIGHT_LAST)) begin
                class_valid_q <= 1'b1;
            end
        end
    end

    assign class_id    = class_q;
    assign class_valid = class_valid_q;
`else
    logic unused_acc;
    assign unused_acc  = ^acc_in;
    assign class_id    = '0;
    assign class_valid = 1'b0;
`endif

endmodule

// File: tb/tb_fc_weight_scheduler.sv
// tb_fc_weight_scheduler
// Scoreboard bench: stimulus pushes the expected acc_clear / result_valid / done
// events with their cycle numbers; a negedge monitor pops and compares them.
module tb_fc_weight_scheduler;

    localparam int FL     = 28;
    localparam int NW     = 10;
    localparam int PER    = FL + 1;      // cycles per weight set
    localparam int DONE_O = 1 + NW * PER; // done period relative to start period (292 cycles inclusive)
`ifdef FC_ARGMAX_EN
    localparam int ARGMAX = 1;
`else
    localparam int ARGMAX = 0;
`endif

    localparam int K_CLR  = 0;
    localparam int K_RV   = 1;
    localparam int K_DONE = 2;

    logic        clk = 1'b0;
    logic        reset, start, abort, pool_valid, mac_ready;
    logic [19:0] acc_in;
    logic        pool_read_en, acc_clear, result_valid, busy, done, class_valid;
    logic [3:0]  weight_num, class_id;
    logic [4:0]  feat_idx;

    int          tbl0 [16];
    int          tbl1 [16];
    logic        tbl_sel;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    int          p;

    typedef struct {
        int kind;
        int cyc;
        int w;
        int cls;
        int cv;
    } ev_t;
    ev_t q[$];

    fc_weight_scheduler #(.FEAT_LEN(FL), .NUM_WEIGHTS(NW), .ACC_W(20)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .pool_valid(pool_valid), .mac_ready(mac_ready), .acc_in(acc_in),
        .pool_read_en(pool_read_en), .weight_num(weight_num), .feat_idx(feat_idx),
        .acc_clear(acc_clear), .result_valid(result_valid), .busy(busy),
        .done(done), .class_id(class_id), .class_valid(class_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // MAC stand-in: the final sum seen in FLUSH depends only on the set index.
    assign acc_in = 20'(tbl_sel ? tbl1[weight_num] : tbl0[weight_num]);

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_pass(input int ps, input int stall_w, input int stall_len,
                             input int n_clr, input int n_rv, input bit with_done,
                             input int cls);
        int sh;
        for (int k = 0; k < NW; k++) begin
            if (k < n_clr) begin
                sh = (k > stall_w) ? stall_len : 0;
                q.push_back('{K_CLR, ps + 1 + PER * k + sh, k, 0, 0});
            end
            if (k < n_rv) begin
                sh = (k >= stall_w) ? stall_len : 0;
                q.push_back('{K_RV, ps + PER * (k + 1) + sh, k, 0, 0});
            end
        end
        if (with_done) begin
            sh = (stall_w < NW) ? stall_len : 0;
            q.push_back('{K_DONE, ps + DONE_O + sh, NW - 1, ARGMAX * cls, ARGMAX});
        end
    endtask

    task automatic expect_ev(input int kind, input string nm);
        ev_t e;
        if (q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s_unexpected: got event at cycle %0d expected none", nm, cyc);
            return;
        end
        e = q.pop_front();
        chk({nm, "_kind"}, kind, e.kind);
        chk({nm, "_cycle"}, cyc, e.cyc);
        chk({nm, "_weight"}, weight_num, e.w);
        if (kind == K_DONE) begin
            chk("done_class_id", class_id, e.cls);
            chk("done_class_valid", class_valid, e.cv);
        end
    endtask

    // Monitor: every strobe the DUT raises must match the head of the scoreboard.
    always @(negedge clk) begin
        if (acc_clear)    expect_ev(K_CLR, "acc_clear");
        if (result_valid) expect_ev(K_RV, "result_valid");
        if (done)         expect_ev(K_DONE, "done");
        if (acc_clear || result_valid || done)
            chk("strobe_exclusive", int'(acc_clear) + int'(result_valid) + int'(done), 1);
    end

    task automatic check_zero(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_weight"}, weight_num, 0);
        chk({nm, "_feat"}, feat_idx, 0);
        chk({nm, "_class_id"}, class_id, 0);
        chk({nm, "_class_valid"}, class_valid, 0);
        chk({nm, "_strobes"}, {pool_read_en, acc_clear, result_valid, done}, 0);
    endtask

    task automatic pulse_start(input int ps);
        goto(ps);
        start = 1'b1;
        goto(ps + 1);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl0 = '{-5, 3, 9, 9, 2, 1, 0, -3, 4, -1, 0, 0, 0, 0, 0, 0};
        for (int k = 0; k < 16; k++) tbl1[k] = (k < NW) ? k - 10 : 0;
        tbl_sel    = 1'b0;
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        pool_valid = 1'b1;
        mac_ready  = 1'b1;
        goto(4);
        reset = 1'b0;
        check_zero("reset");

        // Pass A: no stalls; argmax {-5,3,9,9,...} -> 2 (tie keeps lower index)
        p = cyc + 2;
        push_pass(p, 99, 0, NW, NW, 1'b1, 2);
        pulse_start(p);
        goto(p + DONE_O + 4);
        chk("A_idle_busy", busy, 0);
        chk("A_class_valid_hold", class_valid, ARGMAX);

        // Pass B: 5-cycle mac_ready stall at weight 4, feat 13; ascending negatives -> 9
        tbl_sel = 1'b1;
        p = cyc + 2;
        push_pass(p, 4, 5, NW, NW, 1'b1, 9);
        pulse_start(p);
        chk("B_class_valid_cleared", class_valid, 0);
        goto(p + 4 * PER + 1 + 13);
        chk("B_pre_stall_feat", feat_idx, 13);
        mac_ready = 1'b0;
        goto(p + 4 * PER + 1 + 15);
        chk("B_stall_feat", feat_idx, 13);
        chk("B_stall_weight", weight_num, 4);
        chk("B_stall_read_en", pool_read_en, 0);
        goto(p + 4 * PER + 1 + 18);
        mac_ready = 1'b1;
        goto(p + DONE_O + 5 + 4);

        // Pass C: abort at weight 6, feat 20
        tbl_sel = 1'b0;
        p = cyc + 2;
        push_pass(p, 99, 0, 7, 6, 1'b0, 0);
        pulse_start(p);
        goto(p + 6 * PER + 1 + 20);
        chk("C_pre_abort_weight", weight_num, 6);
        chk("C_pre_abort_feat", feat_idx, 20);
        abort = 1'b1;
        #1;
        chk("C_abort_read_en", pool_read_en, 0);
        goto(p + 6 * PER + 1 + 21);
        abort = 1'b0;
        chk("C_abort_busy", busy, 0);
        chk("C_abort_weight", weight_num, 0);
        chk("C_abort_feat", feat_idx, 0);
        chk("C_abort_class_valid", class_valid, 0);
        goto(cyc + 40);
        chk("C_scoreboard_drained", q.size(), 0);

        // Pass D: clean run after abort
        tbl_sel = 1'b1;
        p = cyc + 2;
        push_pass(p, 99, 0, NW, NW, 1'b1, 9);
        pulse_start(p);
        goto(p + DONE_O + 4);

        // Pass E: start held high until the DONE cycle -> exactly one pass
        tbl_sel = 1'b0;
        p = cyc + 2;
        push_pass(p, 99, 0, NW, NW, 1'b1, 2);
        goto(p);
        start = 1'b1;
        goto(p + DONE_O);
        start = 1'b0;
        goto(cyc + 10);
        chk("E_single_pass_busy", busy, 0);
        chk("E_class_valid_hold", class_valid, ARGMAX);

        // start and abort together in IDLE: abort wins
        goto(cyc + 1);
        start = 1'b1;
        abort = 1'b1;
        goto(cyc + 1);
        start = 1'b0;
        abort = 1'b0;
        chk("SA_busy", busy, 0);
        chk("SA_class_valid", class_valid, 0);
        goto(cyc + 3);
        chk("SA_still_idle", busy, 0);

        // Pass F: reset mid-RUN at weight 2, feat 5
        p = cyc + 2;
        push_pass(p, 99, 0, 3, 2, 1'b0, 0);
        pulse_start(p);
        goto(p + 2 * PER + 1 + 5);
        chk("F_pre_reset_weight", weight_num, 2);
        chk("F_pre_reset_feat", feat_idx, 5);
        reset = 1'b1;
        goto(cyc + 1);
        reset = 1'b0;
        check_zero("F_reset");
        goto(cyc + 40);
        chk("final_scoreboard_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
